// File: rtl/fetch_flush_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_flush_ctrl_pkg
//
// Shared CPU pipeline-control definitions used by the fetch flush controller
// and the pipeline registers it steers.
//
// Contents:
//   BUBBLE_W         width of the bubble/stall down-counter (covers 1..7 cycles)
//   state_e          fetch control FSM states (RUN, FLUSH, STALL), 2-bit encoded
//   sel_e            which request wins arbitration in a given cycle
//   select_request   priority arbiter: mispredict > jump_req > load_use
// ---------------------------------------------------------------------------
package fetch_flush_ctrl_pkg;

    // Enough bits to hold FLUSH_CYCLES-1 or STALL_CYCLES-1 for lengths up to 7.
    localparam int BUBBLE_W = 3;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        FLUSH = 2'b01,
        STALL = 2'b10
    } state_e;

    // Select priority constants, highest priority first after SEL_NONE.
    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_BCPU = 2'b01,
        SEL_JUMP = 2'b10,
        SEL_LOAD = 2'b11
    } sel_e;

    // A mispredict is honoured in every state because it redirects the whole
    // front end. Jumps and load-use hazards raised while a flush or stall is
    // already under way come from wrong-path instructions and are dropped.
    function automatic sel_e select_request(
        input logic mispredict,
        input logic jump_req,
        input logic load_use,
        input logic in_run
    );
        sel_e sel;
        sel = SEL_NONE;
        if (mispredict) begin
            sel = SEL_BCPU;
        end else if (in_run && jump_req) begin
            sel = SEL_JUMP;
        end else if (in_run && load_use) begin
            sel = SEL_LOAD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fetch_flush_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Saturating event counter with synchronous clear.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, clears the count
//   inc      count one event this cycle
//   clr      synchronous clear; takes precedence over inc
//   count    current count, sticks at all-ones once reached
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Clear beats increment so software can zero the counter even while
    // events keep arriving; the all-ones check prevents wrap-around.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_flush_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_flush_ctrl
//
// Fetch-stage flush/stall controller. Turns branch mispredicts, taken jumps
// and load-use hazards into registered wipe/hold controls for the PC and the
// fetch register, and counts redirect events.
//
// Parameters:
//   FLUSH_CYCLES  bubble cycles after a mispredict, including the PC-load cycle (1..7)
//   STALL_CYCLES  fetch-hold cycles per load-use hazard (1..7)
//   CNT_W         width of flush_cnt
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   mispredict  BranchCPU reports wrong-path fetch
//   jump_req    BJComp reports a taken jump
//   load_use    decode reports a load-use hazard
//   ctr_clr     synchronous clear of flush_cnt
//   bcpu_wipe   load BranchCPU PC and inject a NOP into the fetch register
//   jump_wipe   load the jump address, keep the fetched instruction
//   wipe        inject a NOP, keep the current PC
//   wake        1 = fetch register and PC advance, 0 = hold
//   busy        1 whenever the controller is not in RUN
//   flush_cnt   saturating count of accepted mispredicts plus jumps
// ---------------------------------------------------------------------------
module fetch_flush_ctrl
    import fetch_flush_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mispredict,
    input  logic             jump_req,
    input  logic             load_use,
    input  logic             ctr_clr,
    output logic             bcpu_wipe,
    output logic             jump_wipe,
    output logic             wipe,
    output logic             wake,
    output logic             busy,
    output logic [CNT_W-1:0] flush_cnt
);

    // The entry cycle of a flush or stall is itself one of the bubbles, so
    // the counter is loaded with the number of bubbles still to follow.
    localparam logic [BUBBLE_W-1:0] FLUSH_RELOAD = BUBBLE_W'(FLUSH_CYCLES - 1);
    localparam logic [BUBBLE_W-1:0] STALL_RELOAD = BUBBLE_W'(STALL_CYCLES - 1);

    state_e                state;
    state_e                state_n;
    logic [BUBBLE_W-1:0]   bubble_cnt;
    logic [BUBBLE_W-1:0]   bubble_cnt_n;
    logic                  bcpu_wipe_n;
    logic                  jump_wipe_n;
    logic                  wipe_n;
    logic                  wake_n;
    logic                  busy_n;
    logic                  event_inc;
    sel_e                  sel;

    // State and every control output are registered together, so a request
    // sampled on one edge shows up on the outputs right after that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            bubble_cnt <= '0;
            bcpu_wipe  <= 1'b0;
            jump_wipe  <= 1'b0;
            wipe       <= 1'b0;
            wake       <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bubble_cnt <= bubble_cnt_n;
            bcpu_wipe  <= bcpu_wipe_n;
            jump_wipe  <= jump_wipe_n;
            wipe       <= wipe_n;
            wake       <= wake_n;
            busy       <= busy_n;
        end
    end

    // Next-state and next-output logic. Only one arbitration winner can be
    // chosen per cycle, which keeps the three wipe controls mutually
    // exclusive. With no winner, FLUSH and STALL keep wiping while the
    // counter is non-zero and fall back to RUN once it has run out.
    always_comb begin
        state_n      = state;
        bubble_cnt_n = bubble_cnt;
        bcpu_wipe_n  = 1'b0;
        jump_wipe_n  = 1'b0;
        wipe_n       = 1'b0;
        event_inc    = 1'b0;

        sel = select_request(mispredict, jump_req, load_use, state == RUN);

        unique case (sel)
            SEL_BCPU: begin
                bcpu_wipe_n  = 1'b1;
                event_inc    = 1'b1;
                bubble_cnt_n = FLUSH_RELOAD;
                state_n      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end
            SEL_JUMP: begin
                jump_wipe_n = 1'b1;
                event_inc   = 1'b1;
                state_n     = RUN;
            end
            SEL_LOAD: begin
                wipe_n       = 1'b1;
                bubble_cnt_n = STALL_RELOAD;
                state_n      = STALL;
            end
            default: begin
                if (state != RUN) begin
                    if (bubble_cnt != '0) begin
                        wipe_n       = 1'b1;
                        bubble_cnt_n = bubble_cnt - 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
        endcase

        wake_n = (state_n != STALL);
        busy_n = (state_n != RUN);
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (event_inc),
        .clr     (ctr_clr),
        .count   (flush_cnt)
    );

endmodule
